// File: rtl/bus_initiator_if.sv
// Peripheral bus bundle between bus_initiator (master) and the address decoder (slave).
// A transfer is valid with wstrb=0000 for reads; the responder answers with ready and rdata.
interface bus_initiator_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: command port -> bus transfer -> response port.
// Optional ready timeout enabled by defining BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [31:0]            cmd_addr,
    input  logic [31:0]            cmd_wdata,
    input  logic [3:0]             cmd_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    bus_initiator_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    assign cmd_ready = (state == IDLE);

    // Bus addresses are word aligned; the byte offset of the command is dropped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cmd_addr[1:0];

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus.valid <= 1'b0;
            bus.wstrb <= 4'b0000;
            bus.addr  <= 32'h0;
            bus.wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            timer     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write && (cmd_wstrb == 4'b0000)) begin
                            // A write that enables no bytes is rejected without touching the bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            state     <= RESP;
                        end else begin
                            bus.addr  <= {cmd_addr[31:2], 2'b00};
                            bus.wdata <= cmd_wdata;
                            bus.wstrb <= cmd_write ? cmd_wstrb : 4'b0000;
                            bus.valid <= 1'b1;
                            state     <= BUS;
`ifdef BUS_INITIATOR_TIMEOUT_EN
                            timer     <= '0;
`endif
                        end
                    end
                end

                BUS: begin
                    if (bus.ready) begin
                        // Legal writes always carry a nonzero strobe, so wstrb identifies the direction.
                        bus.valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= (bus.wstrb != 4'b0000) ? 32'h0 : bus.rdata;
                        state     <= RESP;
                    end
`ifdef BUS_INITIATOR_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    bus.valid <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: vector table of bus transactions plus hand-written reset/timeout sequences.
module tb_bus_initiator;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    bus_initiator_if bif ();

    bus_initiator #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        int          hold;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk("cmd_ready before cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
    endtask

    // Pops the scoreboard on the first response cycle, holds rsp_ready low, then handshakes.
    task automatic check_rsp(input int hold);
        rsp_t e;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        chk("rsp_valid asserted", rsp_valid, 1);
        chk("cmd_ready low in RESP", cmd_ready, 0);
        chk("scoreboard nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            step();
            bif.ready = 1'b0;
            bif.rdata = $urandom;
            chk("rsp_valid held", rsp_valid, 1);
            chk("rsp_rdata held", rsp_rdata, e.rdata);
            chk("rsp_err held", rsp_err, e.err);
            chk("cmd_ready low while held", cmd_ready, 0);
            chk("valid low while held", bif.valid, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        bif.ready = 1'b0;
        chk("rsp_valid drops", rsp_valid, 0);
        chk("cmd_ready after handshake", cmd_ready, 1);
        chk("valid idle", bif.valid, 0);
    endtask

    task automatic run_vec(input vec_t v);
        rsp_t e;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        issue(v.write, v.addr, v.wdata, v.wstrb);
        if (v.exp_err) begin
            chk("illegal no bus valid", bif.valid, 0);
        end else begin
            for (int c = 0; c <= v.delay; c++) begin
                chk("valid during BUS", bif.valid, 1);
                chk("addr stable", bif.addr, v.exp_addr);
                chk("wdata stable", bif.wdata, v.wdata);
                chk("wstrb stable", bif.wstrb, v.exp_wstrb);
                chk("no rsp during BUS", rsp_valid, 0);
                bif.ready = (c == v.delay);
                bif.rdata = (c == v.delay) ? v.rdata : $urandom;
                step();
            end
            // ready stays high for one more cycle, like a responder that registers it
            chk("valid drops after ready", bif.valid, 0);
        end
        check_rsp(v.hold);
    endtask

    vec_t vecs[6];

    initial begin
        int   cnt;
        rsp_t e;

        bif.ready = 1'b0;
        bif.rdata = 32'h0;

        //          wr    addr          wdata         wstrb dly hold rdata          exp_addr      exp_wstrb exp_rdata     err
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 1,  0,  32'h0000_0001, 32'h0000_0010, 4'h0, 32'h0000_0001, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 3,  0,  32'hFFFF_0000, 32'h0000_0008, 4'h3, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 4'h0, 0,  0,  32'h0,         32'h0,         4'h0, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 0,  5,  32'hCAFE_F00D, 32'h0000_0040, 4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0037, 32'h5555_AAAA, 4'h0, 0,  0,  32'hA5A5_5A5A, 32'h0000_0034, 4'h0, 32'hA5A5_5A5A, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFE, 32'h1234_5678, 4'hF, 2,  1,  32'h0BAD_0BAD, 32'hFFFF_FFFC, 4'hF, 32'h0,         1'b0};

        step();
        step();
        chk("reset valid", bif.valid, 0);
        chk("reset wstrb", bif.wstrb, 0);
        chk("reset addr", bif.addr, 0);
        chk("reset wdata", bif.wdata, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset rsp_err", rsp_err, 0);
        reset = 1'b0;
        step();
        chk("cmd_ready after reset", cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort a read two cycles into BUS with reset.
        issue(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        chk("abort valid cycle 1", bif.valid, 1);
        step();
        chk("abort valid cycle 2", bif.valid, 1);
        reset = 1'b1;
        step();
        chk("abort valid cleared", bif.valid, 0);
        chk("abort rsp_valid cleared", rsp_valid, 0);
        reset = 1'b0;
        step();
        chk("cmd_ready after abort", cmd_ready, 1);
        chk("no response after abort", rsp_valid, 0);
        run_vec(vecs[0]);

        // Responder that never answers.
        issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
        cnt = 0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
        e.rdata = 32'h0;
        e.err   = 1'b1;
        sb.push_back(e);
        for (int c = 0; c < 20 && bif.valid === 1'b1; c++) begin
            cnt++;
            step();
        end
        chk("timeout valid cycles", cnt, TO);
        check_rsp(0);
`else
        for (int c = 0; c < 120; c++) begin
            if (bif.valid === 1'b1 && rsp_valid === 1'b0) cnt++;
            step();
        end
        chk("valid held without ready", cnt, 120);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("valid cleared by reset", bif.valid, 0);
        step();
`endif
        run_vec(vecs[4]);

        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
